acos_lut_engine: RTL
====================

// Module: acos_lut_engine
// PURPOSE
//  Streaming arccos unit for the beamforming angle path: takes signed normalised cosine samples
//  (delay ratio tau*c/d) and returns the angle in rad, fixed-point. Parametrised successor of the
//  fixed 2048x16 acos table: width/depth/scale are generic, a quarter-symmetry fold halves the table,
//  a channel tag and valid/ready handshake with backpressure are added, and interpolation is optional.
// PARAMETERS
//  IN_W      16            input width, signed Q1.(IN_W-1)
//  AW        11            table address bits; DEPTH = 2**AW entries covering |x| in [0,1)
//  OUT_W     16            output angle width, unsigned
//  FRAC      13            output fractional bits; PI_CODE = round(pi*2**FRAC) = 25736 at default
//  CH_W      3             channel tag width
//  INIT_FILE "acos_tab.hex" $readmemh image; entry k = round(acos(k/DEPTH)*2**FRAC)
// PORTS
//  clk        in   1      system clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      input sample valid
//  in_ready   out  1      engine accepts the sample this cycle
//  in_x       in   IN_W   cosine, signed Q1.(IN_W-1)
//  in_ch      in   CH_W   channel tag, passed through unchanged
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts the result
//  out_angle  out  OUT_W  acos(in_x), unsigned, FRAC fractional bits, range [0, PI_CODE]
//  out_ch     out  CH_W   tag of the sample that produced out_angle
// BEHAVIOUR
//  - Reset (async assert, sync release): all stage valids 0, out_valid=0, out_angle=0, out_ch=0.
//  - Pipeline advance en = !out_valid | out_ready; in_ready = en; transfer when in_valid & in_ready.
//    Stall freezes every stage, nothing dropped or duplicated; out_angle/out_ch stable while stalled.
//  - S0: neg = in_x[IN_W-1]; mag = |in_x|, saturate to 2**(IN_W-1)-1 (0x8000 -> 0x7FFF).
//    idx = mag[IN_W-2 -: AW]; fr = low IN_W-1-AW bits of mag (4 bits at default).
//  - S1: synchronous table read t0 = TAB[idx] (1-cycle ROM, read enabled only by en).
//  - S2: fold: a = neg ? PI_CODE - t0 : t0 (no underflow; t0 <= PI_CODE/2+1).
//  - S3: output register. Latency input-accept -> out_valid = 4 cycles with no stalls; throughput 1/clk.
//  - Table stores positive half only; acos(-x) = pi - acos(x) gives exact odd symmetry about PI_CODE/2.
//  - Reset mid-stream: in-flight samples discarded, first post-reset output is a fresh input.
// CONFIGURATION
//  ACOS_INTERP_EN defined: S1 also reads t1 = TAB[min(idx+1, DEPTH-1)] (second read port);
//    extra stage S1b: t = t0 + ((t1-t0)*fr >>> (IN_W-1-AW)), signed math OUT_W+IN_W-AW bits,
//    truncate toward -inf; latency 5. At idx = DEPTH-1, t1=t0 (no extrapolation).
//  Not defined: fr ignored, single read port, latency 4, nearest-lower-entry output.
// STRUCTURE
//  acos_pkg: function pi_code(FRAC), localparams DEPTH, FRB = IN_W-1-AW, stage-valid typedef.
//  Sub-module acos_table_rom: DEPTH x OUT_W sync-read ROM from INIT_FILE, ce input, ports A and
//  (under ACOS_INTERP_EN) B. Engine owns pipeline, fold, handshake, interpolation.
// TESTING
//  1 x=0x0000 ch=2 -> 4 cycles later out_angle=12868 (pi/2), out_ch=2.
//  2 x=0x7FFF -> out_angle=TAB[2047]~256; x=0x8000 and 0x8001 -> both 25736-TAB[2047]~25480.
//  3 Sweep all 2**16 inputs back-to-back, out_ready=1 -> one result/clk, order kept,
//    angle(x)+angle(-x)=25736 for every x!=0x8000, monotonic non-increasing in x.
//  4 Random out_ready (50%) with continuous in_valid -> no loss/dup vs. model; outputs stable when stalled.
//  5 rst_n low for 1 cycle with 3 samples in flight -> out_valid=0 at once, no stale result after release.
//  6 ACOS_INTERP_EN: x=0x0008 -> (TAB[0]+TAB[1])/2 rounded down; x=0x7FFF -> TAB[2047]; latency 5.

Source files
------------

// File: rtl/acos_pkg.sv
// Shared helpers for the arccos engine: pi scaling, table-entry generation and stage valids.
// The stage-valid layout gains an interpolation stage when ACOS_INTERP_EN is defined.
package acos_pkg;

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

    function automatic int frb_of(input int in_w, input int aw);
        return in_w - 1 - aw;
    endfunction

    // pi * 2**48 in hex; rounding adds half an output LSB before the shift
    function automatic int pi_code(input int frac);
        longint unsigned pi48;
        pi48 = 64'h0003_243F_6A88_85A3;
        return int'((pi48 + (64'd1 << (47 - frac))) >> (48 - frac));
    endfunction

    // Evaluated only at elaboration to fill the ROM: round(acos(k/2**aw) * 2**frac)
    function automatic int tab_entry(input int k, input int aw, input int frac);
        real scale;
        real depth;
        scale = 1.0;
        depth = 1.0;
        for (int i = 0; i < frac; i++) scale = scale * 2.0;
        for (int i = 0; i < aw; i++) depth = depth * 2.0;
        return $rtoi($acos($itor(k) / depth) * scale + 0.5);
    endfunction

    typedef struct packed {
        logic p0;
        logic p1;
`ifdef ACOS_INTERP_EN
        logic p1b;
`endif
        logic p2;
    } stage_vld_t;

endpackage

// File: rtl/acos_table_rom.sv
// Synchronous-read arccos ROM covering |x| in [0,1); contents are generated at elaboration.
// Second read port B exists only when ACOS_INTERP_EN is defined.
module acos_table_rom
    import acos_pkg::*;
#(
    parameter int AW    = 11,
    parameter int OUT_W = 16,
    parameter int FRAC  = 13
) (
    input  logic             clk,
    input  logic             ce,
    input  logic [AW-1:0]    addr_a,
    output logic [OUT_W-1:0] q_a
`ifdef ACOS_INTERP_EN
    ,
    input  logic [AW-1:0]    addr_b,
    output logic [OUT_W-1:0] q_b
`endif
);
    localparam int DEPTH = depth_of(AW);

    logic [OUT_W-1:0] rom_data [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_tab
        localparam int CODE = tab_entry(k, AW, FRAC);
        assign rom_data[k] = OUT_W'(CODE);
    end

    always_ff @(posedge clk) begin
        if (ce) q_a <= rom_data[addr_a];
    end

`ifdef ACOS_INTERP_EN
    always_ff @(posedge clk) begin
        if (ce) q_b <= rom_data[addr_b];
    end
`endif

endmodule

// File: rtl/acos_lut_engine.sv
// Streaming arccos engine: |x| fold, half-table lookup, pi-x mirror, valid/ready with backpressure.
// Define ACOS_INTERP_EN for linear interpolation between entries (adds one pipeline stage).
module acos_lut_engine
    import acos_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int AW    = 11,
    parameter int OUT_W = 16,
    parameter int FRAC  = 13,
    parameter int CH_W  = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [IN_W-1:0] in_x,
    input  logic [CH_W-1:0]        in_ch,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_angle,
    output logic [CH_W-1:0]        out_ch
);
    localparam int DEPTH   = depth_of(AW);
    localparam int FRB     = frb_of(IN_W, AW);
    localparam int PI_CODE = pi_code(FRAC);
    localparam int IW      = OUT_W + IN_W - AW;

    // |x| in IN_W-1 bits; the lone value -1.0 saturates to the largest magnitude
    function automatic logic [IN_W-2:0] mag_sat(input logic signed [IN_W-1:0] x);
        logic [IN_W-2:0] low;
        low = x[IN_W-2:0];
        if (!x[IN_W-1]) return low;
        if (low == '0) return '1;
        return -low;
    endfunction

    function automatic logic [OUT_W-1:0] fold_angle(input logic neg, input logic [OUT_W-1:0] t);
        return neg ? OUT_W'(PI_CODE) - t : t;
    endfunction

`ifdef ACOS_INTERP_EN
    // t0 + floor((t1-t0)*fr / 2**FRB); t1 <= t0 so the step is never positive
    function automatic logic [OUT_W-1:0] interp(input logic [OUT_W-1:0] t0,
                                                input logic [OUT_W-1:0] t1,
                                                input logic [FRB-1:0]   fr);
        logic signed [IW-1:0] d;
        logic signed [IW-1:0] f;
        logic signed [IW-1:0] p;
        logic signed [IW-1:0] s;
        d = $signed(IW'(t1)) - $signed(IW'(t0));
        f = $signed(IW'(fr));
        p = (d * f) >>> FRB;
        s = $signed(IW'(t0)) + p;
        return OUT_W'(s);
    endfunction
`endif

    stage_vld_t       vld;
    logic             en;
    logic [IN_W-2:0]  mag;

    logic             neg_p0;
    logic [AW-1:0]    idx_p0;
    logic [CH_W-1:0]  ch_p0;
    logic             neg_p1;
    logic [CH_W-1:0]  ch_p1;
    logic [OUT_W-1:0] t0_p1;
    logic [OUT_W-1:0] a_p2;
    logic [CH_W-1:0]  ch_p2;

    logic             neg_pre;
    logic [OUT_W-1:0] t_pre;
    logic [CH_W-1:0]  ch_pre;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign mag      = mag_sat(in_x);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld       <= '0;
            out_valid <= 1'b0;
            out_angle <= '0;
            out_ch    <= '0;
        end else if (en) begin
            vld.p0    <= in_valid;
            vld.p1    <= vld.p0;
`ifdef ACOS_INTERP_EN
            vld.p1b   <= vld.p1;
            vld.p2    <= vld.p1b;
`else
            vld.p2    <= vld.p1;
`endif
            // S3: output register
            out_valid <= vld.p2;
            out_angle <= a_p2;
            out_ch    <= ch_p2;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            // S0: sign, saturated magnitude split into table index
            neg_p0 <= in_x[IN_W-1];
            idx_p0 <= mag[IN_W-2 -: AW];
            ch_p0  <= in_ch;
            // S1: table read happens in the ROM alongside these
            neg_p1 <= neg_p0;
            ch_p1  <= ch_p0;
            // S2: odd-symmetry fold
            a_p2   <= fold_angle(neg_pre, t_pre);
            ch_p2  <= ch_pre;
        end
    end

`ifdef ACOS_INTERP_EN
    logic [FRB-1:0]   fr_p0;
    logic [FRB-1:0]   fr_p1;
    logic [AW-1:0]    idx_next;
    logic [OUT_W-1:0] t1_p1;
    logic             neg_p1b;
    logic [CH_W-1:0]  ch_p1b;
    logic [OUT_W-1:0] t_p1b;

    // Clamp at the last entry so the top segment never extrapolates
    assign idx_next = (idx_p0 == AW'(DEPTH - 1)) ? idx_p0 : idx_p0 + AW'(1);

    always_ff @(posedge clk) begin
        if (en) begin
            fr_p0   <= mag[FRB-1:0];
            fr_p1   <= fr_p0;
            // S1b: interpolation
            t_p1b   <= interp(t0_p1, t1_p1, fr_p1);
            neg_p1b <= neg_p1;
            ch_p1b  <= ch_p1;
        end
    end

    assign t_pre   = t_p1b;
    assign neg_pre = neg_p1b;
    assign ch_pre  = ch_p1b;

    acos_table_rom #(.AW(AW), .OUT_W(OUT_W), .FRAC(FRAC)) u_rom (
        .clk    (clk),
        .ce     (en),
        .addr_a (idx_p0),
        .q_a    (t0_p1),
        .addr_b (idx_next),
        .q_b    (t1_p1)
    );
`else
    logic unused_fr;
    assign unused_fr = ^mag[FRB-1:0];

    assign t_pre   = t0_p1;
    assign neg_pre = neg_p1;
    assign ch_pre  = ch_p1;

    acos_table_rom #(.AW(AW), .OUT_W(OUT_W), .FRAC(FRAC)) u_rom (
        .clk    (clk),
        .ce     (en),
        .addr_a (idx_p0),
        .q_a    (t0_p1)
    );
`endif

endmodule
